// File: rtl/fft_frame_buffer.sv
// rtl/fft_frame_buffer.sv - ping-pong frame buffer between the window stage and the FFT input stream
//
// Collects signed windowed samples into FRAME_LEN-sample frames in two BRAM banks
// and streams complete frames out as {imag = 0, real = sign-extended sample}.
// Frames that arrive while both banks are occupied are dropped whole.
//
// Ports:
//   clk_in             system clock
//   rst_in             asynchronous active-low reset
//   in_sample          signed windowed sample (DATA_WIDTH)
//   in_valid           one-cycle strobe per sample, no backpressure
//   m_tdata            {imag, real}, each OUT_WIDTH wide, real in the low half
//   m_tvalid           output word valid
//   m_tready           downstream accepts on m_tvalid & m_tready
//   m_tlast            final word of a frame
//   overflow_out       sticky, at least one frame dropped since reset
//   dropped_frames_out saturating count of dropped frames
//
// Build option: BIT_REVERSE_EN - read each frame in bit-reversed address order.

module fft_frame_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 16,
    parameter int FRAME_LEN  = 4096,
    parameter int ADDR_WIDTH = $clog2(FRAME_LEN)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [DATA_WIDTH-1:0]  in_sample,
    input  logic                   in_valid,
    output logic [2*OUT_WIDTH-1:0] m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic                   overflow_out,
    output logic [15:0]            dropped_frames_out
);

    typedef enum logic {WR_FILL, WR_DROP}   wr_state_t;
    typedef enum logic {RD_IDLE, RD_STREAM} rd_state_t;

    logic [DATA_WIDTH-1:0] r_bank0 [FRAME_LEN];
    logic [DATA_WIDTH-1:0] r_bank1 [FRAME_LEN];

    // Writer
    wr_state_t             r_wr_state, w_wr_state_nxt;
    logic                  r_wr_bank;
    logic [ADDR_WIDTH-1:0] r_wr_idx;
    logic [1:0]            r_full;
    logic [15:0]           r_dropped;
    logic                  r_overflow;

    // Reader
    rd_state_t             r_rd_state, w_rd_state_nxt;
    logic                  r_rd_bank;
    logic [ADDR_WIDTH:0]   r_rd_cnt;      // MSB set once every address has been issued
    logic [DATA_WIDTH-1:0] r_rd_q;
    logic                  r_rd_vld, r_rd_last;
    logic [DATA_WIDTH-1:0] r_out_data, r_skid_data;
    logic                  r_out_vld, r_out_last, r_skid_vld, r_skid_last;

    logic                  w_wr_other, w_other_empty, w_wr_frame_end, w_fill_write;
    logic                  w_rd_free, w_rd_pick, w_room, w_issue, w_rd_bank_sel;
    logic [ADDR_WIDTH-1:0] w_rd_cnt_cur, w_rd_addr;

    assign w_wr_other     = ~r_wr_bank;
    assign w_wr_frame_end = in_valid && (r_wr_idx == ADDR_WIDTH'(FRAME_LEN - 1));
    assign w_fill_write   = in_valid && (r_wr_state == WR_FILL);
    assign w_rd_free      = r_out_vld && m_tready && r_out_last;
    // A bank released by the reader on this edge counts as empty for the writer.
    assign w_other_empty  = !r_full[w_wr_other] || (w_rd_free && (r_rd_bank == w_wr_other));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_wr_state <= WR_FILL;
        else         r_wr_state <= w_wr_state_nxt;
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        if (w_wr_frame_end)
            w_wr_state_nxt = w_other_empty ? WR_FILL : WR_DROP;
    end

    // The index wraps to 0 on its own at the frame boundary (FRAME_LEN is a power of 2).
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wr_bank  <= 1'b0;
            r_wr_idx   <= '0;
            r_overflow <= 1'b0;
            r_dropped  <= '0;
        end else if (in_valid) begin
            r_wr_idx <= r_wr_idx + ADDR_WIDTH'(1);
            if (w_wr_frame_end && w_other_empty)
                r_wr_bank <= w_wr_other;
            if (w_wr_frame_end && r_wr_state == WR_DROP) begin
                r_overflow <= 1'b1;
                if (r_dropped != 16'hFFFF)
                    r_dropped <= r_dropped + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_full <= 2'b00;
        end else begin
            if (w_rd_free)
                r_full[r_rd_bank] <= 1'b0;
            if (w_fill_write && w_wr_frame_end)
                r_full[r_wr_bank] <= 1'b1;
        end
    end

    // Reader: a read is issued only if the word it returns next cycle is guaranteed
    // a place in either the output register or the (then empty) skid entry.
    assign w_rd_pick     = r_full[0] ? 1'b0 : 1'b1;
    assign w_room        = !r_skid_vld && !(r_rd_vld && r_out_vld && !m_tready);
    assign w_issue       = w_room && (((r_rd_state == RD_IDLE) && (|r_full)) ||
                                      ((r_rd_state == RD_STREAM) && !r_rd_cnt[ADDR_WIDTH]));
    assign w_rd_bank_sel = (r_rd_state == RD_IDLE) ? w_rd_pick : r_rd_bank;
    assign w_rd_cnt_cur  = (r_rd_state == RD_IDLE) ? '0 : r_rd_cnt[ADDR_WIDTH-1:0];

    always_comb begin
        w_rd_addr = w_rd_cnt_cur;
`ifdef BIT_REVERSE_EN
        for (int i = 0; i < ADDR_WIDTH; i++)
            w_rd_addr[i] = w_rd_cnt_cur[ADDR_WIDTH-1-i];
`endif
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_rd_state <= RD_IDLE;
        else         r_rd_state <= w_rd_state_nxt;
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            RD_IDLE:   if (w_issue)   w_rd_state_nxt = RD_STREAM;
            RD_STREAM: if (w_rd_free) w_rd_state_nxt = RD_IDLE;
            default:                  w_rd_state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (w_fill_write) begin
            if (r_wr_bank) r_bank1[r_wr_idx] <= in_sample;
            else           r_bank0[r_wr_idx] <= in_sample;
        end
        if (w_issue)
            r_rd_q <= w_rd_bank_sel ? r_bank1[w_rd_addr] : r_bank0[w_rd_addr];
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_rd_bank <= 1'b0;
            r_rd_cnt  <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
        end else begin
            r_rd_vld  <= w_issue;
            r_rd_last <= w_issue && (w_rd_cnt_cur == ADDR_WIDTH'(FRAME_LEN - 1));
            if (w_issue) begin
                r_rd_cnt <= (ADDR_WIDTH + 1)'(w_rd_cnt_cur) + (ADDR_WIDTH + 1)'(1);
                if (r_rd_state == RD_IDLE)
                    r_rd_bank <= w_rd_pick;
            end
        end
    end

    // Output register with one skid entry; the skid always drains first.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_out_vld   <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_skid_vld  <= 1'b0;
            r_skid_last <= 1'b0;
            r_skid_data <= '0;
        end else if (!r_out_vld || m_tready) begin
            if (r_skid_vld) begin
                r_out_vld   <= 1'b1;
                r_out_last  <= r_skid_last;
                r_out_data  <= r_skid_data;
                r_skid_vld  <= r_rd_vld;
                r_skid_last <= r_rd_last;
                r_skid_data <= r_rd_q;
            end else begin
                r_out_vld  <= r_rd_vld;
                r_out_last <= r_rd_last;
                if (r_rd_vld)
                    r_out_data <= r_rd_q;
            end
        end else if (r_rd_vld) begin
            r_skid_vld  <= 1'b1;
            r_skid_last <= r_rd_last;
            r_skid_data <= r_rd_q;
        end
    end

    assign m_tdata            = {{OUT_WIDTH{1'b0}}, OUT_WIDTH'($signed(r_out_data))};
    assign m_tvalid           = r_out_vld;
    assign m_tlast            = r_out_last;
    assign overflow_out       = r_overflow;
    assign dropped_frames_out = r_dropped;

endmodule
